// File: rtl/mem_pkg.sv
// Shared constants and types for the line-wide backing memory model.
package mem_pkg;

  localparam int unsigned LINE_W      = 128;
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mem_state_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port DEPTH x LINE_W synchronous RAM with registered, enabled read; no reset.
module mem_line_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LINE_W = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [LINE_W-1:0]        wdata_i,
  output logic [LINE_W-1:0]        rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_model.sv
// Backing memory for the cache refill/write-back port: one line request at a time,
// ready held low for LATENCY cycles, then one DONE cycle.
module main_memory_model
  import mem_pkg::*;
#(
  parameter int unsigned LINE_W  = mem_pkg::LINE_W,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_dataout,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  output logic [LINE_W-1:0] mem_req_datain,
  output logic              mem_req_ready
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              rw_q, rw_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] datain_q, datain_d;

  logic              ram_we, ram_re;
  logic [IdxW-1:0]   ram_addr;
  logic [LINE_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mem_req_addr[31:OFFSET_BITS+IdxW], mem_req_addr[OFFSET_BITS-1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    datain_d = datain_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = idx_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_valid) begin
          idx_d    = mem_req_addr[OFFSET_BITS +: IdxW];
          rw_d     = mem_req_rw;
          wdata_d  = mem_req_dataout;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = StBusy;
          // Fetch the line at acceptance; nothing else can write it before completion.
          ram_addr = mem_req_addr[OFFSET_BITS +: IdxW];
          ram_re   = ~mem_req_rw & ~rst;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (rw_q) begin
            ram_we = ~rst;
          end else begin
            datain_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      datain_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      datain_q <= datain_d;
    end
  end

  mem_line_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign mem_req_ready  = (state_q != StBusy);
  assign mem_req_datain = datain_q;

endmodule

// File: tb/tb_main_memory_model.sv
// Scoreboard bench: dut0 runs LATENCY=4, dut1 runs LATENCY=1; both share one expect queue.
module tb_main_memory_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst   = 2'b11;
  logic [1:0]        valid = 2'b00;
  logic [1:0]        rw    = 2'b00;
  logic [1:0][31:0]  addr  = '0;
  logic [1:0][127:0] dout  = '0;
  wire  [1:0]        ready;
  wire  [1:0][127:0] datain;

  main_memory_model #(.LINE_W(128), .DEPTH(1024), .LATENCY(4)) dut0 (
    .clk             (clk),
    .rst             (rst[0]),
    .mem_req_addr    (addr[0]),
    .mem_req_dataout (dout[0]),
    .mem_req_rw      (rw[0]),
    .mem_req_valid   (valid[0]),
    .mem_req_datain  (datain[0]),
    .mem_req_ready   (ready[0])
  );

  main_memory_model #(.LINE_W(128), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clk             (clk),
    .rst             (rst[1]),
    .mem_req_addr    (addr[1]),
    .mem_req_dataout (dout[1]),
    .mem_req_rw      (rw[1]),
    .mem_req_valid   (valid[1]),
    .mem_req_datain  (datain[1]),
    .mem_req_ready   (ready[1])
  );

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  logic [127:0] hold[2] = '{128'h0, 128'h0};
  bit b2b_mode = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: completion is a rising ready that was not caused by a reset.
  int       cyc = 0;
  int       busy[2] = '{0, 0};
  int       last_done[2] = '{-1, -1};
  int       lat_of[2] = '{4, 1};
  logic [1:0] prev_ready = 2'b11;
  logic [1:0] prev_rst = 2'b00;

  always @(negedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (!b2b_mode) last_done[g] = -1;
      if (prev_rst[g]) begin
        check($sformatf("post_reset_ready%0d", g), {127'b0, ready[g]}, 128'd1);
        check($sformatf("post_reset_datain%0d", g), datain[g], 128'h0);
        busy[g] = 0;
      end else if (!ready[g]) begin
        busy[g]++;
      end else if (!prev_ready[g]) begin
        check($sformatf("latency%0d", g), 128'(busy[g]), 128'(lat_of[g]));
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_completion%0d", g), 128'd1, 128'd0);
        end else begin
          check($sformatf("datain%0d", g), datain[g], exp_q.pop_front());
        end
        if (b2b_mode && last_done[g] >= 0)
          check($sformatf("b2b_gap%0d", g), 128'(cyc - last_done[g]), 128'(lat_of[g] + 2));
        last_done[g] = cyc;
        busy[g] = 0;
      end
      prev_ready[g] = ready[g];
      prev_rst[g]   = rst[g];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int g, input logic lvl, input string nm);
    int n = 0;
    while (ready[g] !== lvl && n < 50) begin
      tick();
      n++;
    end
    if (ready[g] !== lvl) check(nm, {127'b0, ready[g]}, {127'b0, lvl});
  endtask

  task automatic req(input int g, input logic [31:0] a, input logic w, input logic [127:0] d,
                     input logic [127:0] exp_rd);
    addr[g] = a; rw[g] = w; dout[g] = d; valid[g] = 1'b1;
    tick();
    wait_ready(g, 1'b0, "accept_timeout");
    valid[g] = 1'b0;
    if (w) begin
      exp_q.push_back(hold[g]);
    end else begin
      exp_q.push_back(exp_rd);
      hold[g] = exp_rd;
    end
    // Scribble on inputs during BUSY; they must be ignored.
    addr[g] = 32'hFFFF_FFF0; dout[g] = '1; rw[g] = ~w;
    wait_ready(g, 1'b1, "done_timeout");
  endtask

  task automatic b2b(input int g, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [127:0] d0, input logic [127:0] d1);
    b2b_mode = 1'b1;
    addr[g] = a0; rw[g] = 1'b0; valid[g] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(g, 1'b1, "b2b_idle_timeout");
      wait_ready(g, 1'b0, "b2b_accept_timeout");
      exp_q.push_back((k % 2) ? d1 : d0);
      hold[g] = (k % 2) ? d1 : d0;
      addr[g] = (k % 2) ? a0 : a1;
    end
    valid[g] = 1'b0;
    wait_ready(g, 1'b1, "b2b_done_timeout");
    tick();
    b2b_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready", {127'b0, ready[0]}, 128'd1);
    end
    check("idle_datain", datain[0], 128'h0);

    // LATENCY=4
    req(0, 32'h0000_AB00, 1'b1, 128'h1122, 128'h0);
    req(0, 32'h0000_AB00, 1'b0, 128'h0, 128'h1122);
    req(0, 32'h0000_BB00, 1'b0, 128'h0, 128'h0);
    req(0, 32'h0000_AB00, 1'b0, 128'h0, 128'h1122);
    req(0, 32'h0000_EB00, 1'b1, 128'h5566, 128'h0);
    req(0, 32'h0000_AB00, 1'b0, 128'h0, 128'h5566);  // 0xEB00 aliases 0xAB00 at DEPTH=1024
    req(0, 32'h0000_4010, 1'b1, 128'h3344, 128'h0);
    req(0, 32'h0000_0010, 1'b0, 128'h0, 128'h3344);
    req(0, 32'h0000_0018, 1'b0, 128'h0, 128'h3344);

    // Reset in the 2nd BUSY cycle aborts the write.
    addr[0] = 32'h0000_CC00; rw[0] = 1'b1; dout[0] = 128'hDEAD; valid[0] = 1'b1;
    tick();
    wait_ready(0, 1'b0, "abort_accept_timeout");
    valid[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    hold[0] = 128'h0;
    tick();
    req(0, 32'h0000_CC00, 1'b0, 128'h0, 128'h0);

    b2b(0, 32'h0000_AB00, 32'h0000_BB00, 128'h5566, 128'h0);

    // LATENCY=1
    req(1, 32'h0000_AB00, 1'b1, 128'h1122, 128'h0);
    req(1, 32'h0000_AB00, 1'b0, 128'h0, 128'h1122);
    b2b(1, 32'h0000_AB00, 32'h0000_BB00, 128'h1122, 128'h0);

    repeat (5) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
